// File: rtl/pic_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic_seq_pkg                                                                |
// | Shared types and constants for the 8259A host-side bus sequencer.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pic_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_I_ICW1 = 4'd1,
        ST_I_ICW2 = 4'd2,
        ST_I_ICW3 = 4'd3,
        ST_I_ICW4 = 4'd4,
        ST_I_OCW1 = 4'd5,
        ST_C_WR   = 4'd6,
        ST_C_RD   = 4'd7,
        ST_INTA1  = 4'd8,
        ST_IGAP   = 4'd9,
        ST_INTA2  = 4'd10,
`ifdef PIC_SEQ_AUTO_EOI_EN
        ST_EOI    = 4'd11,
`endif
        ST_RECOV  = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CYC_WR    = 3'd0,
        CYC_RD    = 3'd1,
        CYC_INTA  = 3'd2,
        CYC_GAP   = 3'd3,
        CYC_RECOV = 3'd4
    } cyc_kind_t;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_SETUP = 3'd1,
        PH_PULSE = 3'd2,
        PH_HOLD  = 3'd3,
        PH_WAIT  = 3'd4
    } phase_t;

    localparam logic       A0_CMD      = 1'b0;
    localparam logic       A0_DATA     = 1'b1;
    localparam logic [7:0] OCW2_NS_EOI = 8'h20;
    localparam int         ICW1_SNGL   = 1;
    localparam int         ICW1_IC4    = 0;

    // Word that follows cur in the init chain; ICW3/ICW4 are optional per ICW1.
    function automatic state_t next_init_word(input state_t cur, input logic [7:0] icw1);
        state_t nxt;
        nxt = ST_I_OCW1;
        case (cur)
            ST_I_ICW1: nxt = ST_I_ICW2;
            ST_I_ICW2: begin
                if (!icw1[ICW1_SNGL])     nxt = ST_I_ICW3;
                else if (icw1[ICW1_IC4])  nxt = ST_I_ICW4;
            end
            ST_I_ICW3: if (icw1[ICW1_IC4]) nxt = ST_I_ICW4;
            default:   nxt = ST_I_OCW1;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_bus_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic_bus_cycle                                                              |
// | Timer and strobe driver for one PIC bus cycle (WR/RD frame, INTA pulse,    |
// | INTA gap or recovery idle). Started by the sequencer, reports done.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pic_bus_cycle
    import pic_seq_pkg::*;
#(
    parameter int WR_PULSE   = 2,
    parameter int RD_PULSE   = 2,
    parameter int INTA_PULSE = 2,
    parameter int INTA_GAP   = 1,
    parameter int RECOVERY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  cyc_kind_t   i_kind,
    input  logic        i_a0,
    input  logic [7:0]  i_wdata,
    output logic        o_done,
    output logic        o_sample,
    output logic        o_cs_n,
    output logic        o_rd_n,
    output logic        o_wr_n,
    output logic        o_inta_n,
    output logic        o_a0,
    output logic [7:0]  o_d_out,
    output logic        o_d_oe
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] c_wr_last   = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] c_rd_last   = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] c_inta_last = CNT_W'(INTA_PULSE - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(INTA_GAP - 1);
    localparam logic [CNT_W-1:0] c_rec_last  = CNT_W'(RECOVERY - 1);

    phase_t           phase_q, phase_d;
    cyc_kind_t        kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a0_q, a0_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] w_last;
    logic             w_at_last;
    logic             w_frame;

    always_comb begin
        w_last = c_rec_last;
        case (kind_q)
            CYC_WR:   w_last = c_wr_last;
            CYC_RD:   w_last = c_rd_last;
            CYC_INTA: w_last = c_inta_last;
            CYC_GAP:  w_last = c_gap_last;
            default:  w_last = c_rec_last;
        endcase
    end

    assign w_at_last = (cnt_q == w_last);

    // A start always coincides with done of the previous cycle, so cycles chain without gaps.
    always_comb begin
        phase_d = phase_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        a0_d    = a0_q;
        data_d  = data_q;
        if (i_start) begin
            kind_d = i_kind;
            cnt_d  = '0;
            case (i_kind)
                CYC_WR: begin
                    phase_d = PH_SETUP;
                    a0_d    = i_a0;
                    data_d  = i_wdata;
                end
                CYC_RD: begin
                    phase_d = PH_SETUP;
                    a0_d    = i_a0;
                end
                CYC_INTA: phase_d = PH_PULSE;
                default:  phase_d = PH_WAIT;
            endcase
        end else begin
            case (phase_q)
                PH_SETUP: phase_d = PH_PULSE;
                PH_PULSE: begin
                    if (w_at_last) phase_d = (kind_q == CYC_INTA) ? PH_IDLE : PH_HOLD;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
                PH_HOLD:  phase_d = PH_IDLE;
                PH_WAIT: begin
                    if (w_at_last) phase_d = PH_IDLE;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
                default:  phase_d = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            kind_q  <= CYC_RECOV;
            cnt_q   <= '0;
            a0_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            a0_q    <= a0_d;
            data_q  <= data_d;
        end
    end

    assign w_frame  = ((kind_q == CYC_WR) || (kind_q == CYC_RD)) &&
                      (phase_q inside {PH_SETUP, PH_PULSE, PH_HOLD});
    assign o_cs_n   = !w_frame;
    assign o_wr_n   = !((kind_q == CYC_WR)   && (phase_q == PH_PULSE));
    assign o_rd_n   = !((kind_q == CYC_RD)   && (phase_q == PH_PULSE));
    assign o_inta_n = !((kind_q == CYC_INTA) && (phase_q == PH_PULSE));
    assign o_d_oe   = w_frame && (kind_q == CYC_WR);
    assign o_a0     = a0_q;
    assign o_d_out  = data_q;

    assign o_done   = (phase_q == PH_HOLD) ||
                      (w_at_last && (phase_q == PH_WAIT)) ||
                      (w_at_last && (phase_q == PH_PULSE) && (kind_q == CYC_INTA));
    assign o_sample = w_at_last && (phase_q == PH_PULSE) &&
                      ((kind_q == CYC_RD) || (kind_q == CYC_INTA));

endmodule
`default_nettype wire

// File: rtl/pic_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pic_host_sequencer                                                         |
// | 8259A host-side sequencer: ICW/OCW1 init, host command arbitration against |
// | INTA cycles, vector capture. Option: PIC_SEQ_AUTO_EOI_EN adds an automatic |
// | non-specific EOI write after each acknowledged vector.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pic_host_sequencer
    import pic_seq_pkg::*;
#(
    parameter int WR_PULSE   = 2,
    parameter int RD_PULSE   = 2,
    parameter int INTA_PULSE = 2,
    parameter int INTA_GAP   = 1,
    parameter int RECOVERY   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       pic_int,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       pic_cs_n,
    output logic       pic_rd_n,
    output logic       pic_wr_n,
    output logic       pic_inta_n,
    output logic       pic_a0,
    output logic [7:0] pic_d_out,
    output logic       pic_d_oe,
    input  logic [7:0] pic_d_in,
    output logic       busy
);

    state_t     state_q, state_d, ret_q, ret_d;
    logic       init_done_q, init_done_d;
    logic       init_pend_q, init_pend_d;
    logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d;
    logic [7:0] icw4_q, icw4_d, ocw1_q, ocw1_d;
    logic       int_meta_q, int_meta_d, int_s_q, int_s_d;
    logic       rsp_valid_q, rsp_valid_d, vec_valid_q, vec_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d, vec_data_q, vec_data_d;

    logic       w_bus_start, w_bus_done, w_bus_sample, w_bus_a0;
    cyc_kind_t  w_bus_kind;
    logic [7:0] w_bus_wdata;

    assign int_meta_d = pic_int;
    assign int_s_d    = int_meta_q;

    assign cmd_ready = (state_q == ST_IDLE) && init_done_q && !int_s_q && !init_start;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        init_done_d = init_done_q;
        init_pend_d = init_pend_q;
        icw1_d      = icw1_q;
        icw2_d      = icw2_q;
        icw3_d      = icw3_q;
        icw4_d      = icw4_q;
        ocw1_d      = ocw1_q;
        rsp_valid_d = 1'b0;
        vec_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        vec_data_d  = vec_data_q;
        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d     = ST_I_ICW1;
                    init_done_d = 1'b0;
                    icw1_d      = icw1;
                    icw2_d      = icw2;
                    icw3_d      = icw3;
                    icw4_d      = icw4;
                    ocw1_d      = ocw1;
                end else if (init_done_q && int_s_q) begin
                    state_d = ST_INTA1;
                end else if (cmd_valid && cmd_ready) begin
                    state_d = cmd_wr ? ST_C_WR : ST_C_RD;
                end
            end
            ST_I_ICW1, ST_I_ICW2, ST_I_ICW3, ST_I_ICW4: begin
                if (w_bus_done) begin
                    state_d = ST_RECOV;
                    ret_d   = next_init_word(state_q, icw1_q);
                end
            end
            ST_I_OCW1: begin
                if (w_bus_done) begin
                    state_d     = ST_RECOV;
                    ret_d       = ST_IDLE;
                    init_pend_d = 1'b1;
                end
            end
            ST_C_WR: begin
                if (w_bus_done) begin
                    state_d = ST_RECOV;
                    ret_d   = ST_IDLE;
                end
            end
            ST_C_RD: begin
                if (w_bus_sample) begin
                    rsp_rdata_d = pic_d_in;
                    rsp_valid_d = 1'b1;
                end
                if (w_bus_done) begin
                    state_d = ST_RECOV;
                    ret_d   = ST_IDLE;
                end
            end
            // The acknowledge runs to completion even if INT drops meanwhile.
            ST_INTA1: if (w_bus_done) state_d = ST_IGAP;
            ST_IGAP:  if (w_bus_done) state_d = ST_INTA2;
            ST_INTA2: begin
                if (w_bus_sample) begin
                    vec_data_d  = pic_d_in;
                    vec_valid_d = 1'b1;
                end
                if (w_bus_done) begin
`ifdef PIC_SEQ_AUTO_EOI_EN
                    state_d = ST_EOI;
`else
                    state_d = ST_RECOV;
`endif
                    ret_d   = ST_IDLE;
                end
            end
`ifdef PIC_SEQ_AUTO_EOI_EN
            ST_EOI: begin
                if (w_bus_done) begin
                    state_d = ST_RECOV;
                    ret_d   = ST_IDLE;
                end
            end
`endif
            ST_RECOV: begin
                if (w_bus_done) begin
                    state_d = ret_q;
                    if (init_pend_q) begin
                        init_done_d = 1'b1;
                        init_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every entry into a non-idle state launches that state's bus cycle.
    always_comb begin
        w_bus_start = (state_d != state_q) && (state_d != ST_IDLE);
        w_bus_kind  = CYC_RECOV;
        w_bus_a0    = A0_DATA;
        w_bus_wdata = 8'h00;
        case (state_d)
            ST_I_ICW1: begin
                w_bus_kind  = CYC_WR;
                w_bus_a0    = A0_CMD;
                w_bus_wdata = icw1_d;
            end
            ST_I_ICW2: begin w_bus_kind = CYC_WR; w_bus_wdata = icw2_d; end
            ST_I_ICW3: begin w_bus_kind = CYC_WR; w_bus_wdata = icw3_d; end
            ST_I_ICW4: begin w_bus_kind = CYC_WR; w_bus_wdata = icw4_d; end
            ST_I_OCW1: begin w_bus_kind = CYC_WR; w_bus_wdata = ocw1_d; end
            ST_C_WR: begin
                w_bus_kind  = CYC_WR;
                w_bus_a0    = cmd_a0;
                w_bus_wdata = cmd_wdata;
            end
            ST_C_RD: begin
                w_bus_kind = CYC_RD;
                w_bus_a0   = cmd_a0;
            end
            ST_INTA1, ST_INTA2: w_bus_kind = CYC_INTA;
            ST_IGAP:            w_bus_kind = CYC_GAP;
`ifdef PIC_SEQ_AUTO_EOI_EN
            ST_EOI: begin
                w_bus_kind  = CYC_WR;
                w_bus_a0    = A0_CMD;
                w_bus_wdata = OCW2_NS_EOI;
            end
`endif
            default: w_bus_kind = CYC_RECOV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            init_done_q <= 1'b0;
            init_pend_q <= 1'b0;
            icw1_q      <= 8'h00;
            icw2_q      <= 8'h00;
            icw3_q      <= 8'h00;
            icw4_q      <= 8'h00;
            ocw1_q      <= 8'h00;
            int_meta_q  <= 1'b0;
            int_s_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            vec_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            vec_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            init_done_q <= init_done_d;
            init_pend_q <= init_pend_d;
            icw1_q      <= icw1_d;
            icw2_q      <= icw2_d;
            icw3_q      <= icw3_d;
            icw4_q      <= icw4_d;
            ocw1_q      <= ocw1_d;
            int_meta_q  <= int_meta_d;
            int_s_q     <= int_s_d;
            rsp_valid_q <= rsp_valid_d;
            vec_valid_q <= vec_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            vec_data_q  <= vec_data_d;
        end
    end

    pic_bus_cycle #(
        .WR_PULSE   (WR_PULSE),
        .RD_PULSE   (RD_PULSE),
        .INTA_PULSE (INTA_PULSE),
        .INTA_GAP   (INTA_GAP),
        .RECOVERY   (RECOVERY)
    ) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_bus_start),
        .i_kind   (w_bus_kind),
        .i_a0     (w_bus_a0),
        .i_wdata  (w_bus_wdata),
        .o_done   (w_bus_done),
        .o_sample (w_bus_sample),
        .o_cs_n   (pic_cs_n),
        .o_rd_n   (pic_rd_n),
        .o_wr_n   (pic_wr_n),
        .o_inta_n (pic_inta_n),
        .o_a0     (pic_a0),
        .o_d_out  (pic_d_out),
        .o_d_oe   (pic_d_oe)
    );

    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pic_host_sequencer                                                      |
// | Self-checking bench: pin monitor plus rule-based expectations.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pic_host_sequencer;

    localparam int EV_W = 1;
    localparam int EV_R = 2;
    localparam int EV_I = 3;

    typedef struct {
        int         k;
        logic       a0;
        logic [7:0] d;
        int         w;
        int         gap;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_start = 1'b0;
    logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw1 = '0;
    logic       cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_a0 = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       pic_int = 1'b0;
    logic [7:0] pic_d_in = '0;
    logic       init_done, cmd_ready, rsp_valid, vec_valid, busy;
    logic [7:0] rsp_rdata, vec_data, pic_d_out;
    logic       pic_cs_n, pic_rd_n, pic_wr_n, pic_inta_n, pic_a0, pic_d_oe;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pic_host_sequencer dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
        .init_done(init_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .pic_int(pic_int),
        .vec_valid(vec_valid), .vec_data(vec_data), .pic_cs_n(pic_cs_n),
        .pic_rd_n(pic_rd_n), .pic_wr_n(pic_wr_n), .pic_inta_n(pic_inta_n),
        .pic_a0(pic_a0), .pic_d_out(pic_d_out), .pic_d_oe(pic_d_oe),
        .pic_d_in(pic_d_in), .busy(busy)
    );

    // Pin monitor: turns strobe activity into a list of bus events.
    ev_t  ev_q[$];
    int   cs_runs[$];
    int   wr_w = 0, rd_w = 0, in_w = 0, in_hi = 0, in_gap = 0, cs_run = 0;
    int   bad_oe = 0, bad_cs_inta = 0, bad_rsp_slot = 0, n_rsp = 0, n_vec = 0;
    logic cur_a0 = 1'b0;
    logic [7:0] cur_d = '0;
    logic p_wr = 1'b1, p_rd = 1'b1, p_in = 1'b1;

    always @(negedge clk) begin
        if (!pic_wr_n) begin
            if (p_wr) begin cur_a0 = pic_a0; cur_d = pic_d_out; wr_w = 0; end
            wr_w++;
            if (!pic_d_oe || pic_cs_n) bad_oe++;
        end else if (!p_wr) begin
            ev_q.push_back('{EV_W, cur_a0, cur_d, wr_w, 0});
        end
        if (!pic_rd_n) begin
            if (p_rd) begin cur_a0 = pic_a0; rd_w = 0; end
            rd_w++;
            if (pic_d_oe || pic_cs_n) bad_oe++;
        end else if (!p_rd) begin
            ev_q.push_back('{EV_R, cur_a0, 8'h00, rd_w, 0});
        end
        if (!pic_inta_n) begin
            if (p_in) begin in_gap = in_hi; in_w = 0; end
            in_w++;
            if (!pic_cs_n) bad_cs_inta++;
        end else begin
            if (!p_in) begin ev_q.push_back('{EV_I, 1'b0, 8'h00, in_w, in_gap}); in_hi = 0; end
            in_hi++;
        end
        if (!pic_cs_n) cs_run++;
        else if (cs_run > 0) begin cs_runs.push_back(cs_run); cs_run = 0; end
        if (rsp_valid) begin
            n_rsp++;
            if (pic_rd_n !== 1'b1 || pic_cs_n !== 1'b0) bad_rsp_slot++;
        end
        if (vec_valid) n_vec++;
        p_wr = pic_wr_n;
        p_rd = pic_rd_n;
        p_in = pic_inta_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_init(input logic [7:0] w1, w2, w3, w4, w5);
        ev_t exp_q[$];
        int  base, cbase, n;
        exp_q.push_back('{EV_W, 1'b0, w1, 2, 0});
        exp_q.push_back('{EV_W, 1'b1, w2, 2, 0});
        if (!w1[1]) exp_q.push_back('{EV_W, 1'b1, w3, 2, 0});
        if (w1[0])  exp_q.push_back('{EV_W, 1'b1, w4, 2, 0});
        exp_q.push_back('{EV_W, 1'b1, w5, 2, 0});
        base  = ev_q.size();
        cbase = cs_runs.size();
        icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; ocw1 = w5;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        chk("init_busy", busy, 1);
        chk("init_done_cleared", init_done, 0);
        n = 0;
        while (!init_done && n < 200) begin step(); n++; end
        chk("init_cycles", n, 6 * exp_q.size());
        chk("init_nwrites", ev_q.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            if (base + i < ev_q.size()) begin
                chk("init_kind", ev_q[base+i].k, EV_W);
                chk("init_a0", ev_q[base+i].a0, exp_q[i].a0);
                chk("init_data", ev_q[base+i].d, exp_q[i].d);
                chk("init_wr_width", ev_q[base+i].w, 2);
            end
            if (cbase + i < cs_runs.size()) chk("init_cs_frame", cs_runs[cbase+i], 4);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic a0, input logic [7:0] d, input logic [7:0] rv);
        int base, rbase, n;
        base  = ev_q.size();
        rbase = n_rsp;
        pic_d_in = rv; cmd_wr = wr; cmd_a0 = a0; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk("cmd_cycles", n, 6);
        chk("cmd_nev", ev_q.size() - base, 1);
        if (ev_q.size() > base) begin
            chk("cmd_kind", ev_q[base].k, wr ? EV_W : EV_R);
            chk("cmd_a0", ev_q[base].a0, a0);
            chk("cmd_width", ev_q[base].w, 2);
            if (wr) chk("cmd_wdata", ev_q[base].d, d);
        end
        if (!wr) begin
            chk("rsp_rdata", rsp_rdata, rv);
            chk("rsp_count", n_rsp - rbase, 1);
        end
    endtask

    task automatic check_inta_events(input int base);
        if (ev_q.size() > base + 1) begin
            chk("inta1_kind", ev_q[base].k, EV_I);
            chk("inta1_width", ev_q[base].w, 2);
            chk("inta2_kind", ev_q[base+1].k, EV_I);
            chk("inta2_width", ev_q[base+1].w, 2);
            chk("inta_gap", ev_q[base+1].gap, 1);
        end
`ifdef PIC_SEQ_AUTO_EOI_EN
        if (ev_q.size() > base + 2) begin
            chk("eoi_kind", ev_q[base+2].k, EV_W);
            chk("eoi_a0", ev_q[base+2].a0, 0);
            chk("eoi_data", ev_q[base+2].d, 8'h20);
        end
`endif
    endtask

    task automatic run_inta(input logic [7:0] v);
        int base, vbase, n;
        base  = ev_q.size();
        vbase = n_vec;
        pic_d_in = v;
        pic_int  = 1'b1;
        n = 0;
        while (pic_inta_n && n < 20) begin step(); n++; end
        chk("inta_start", pic_inta_n, 0);
        pic_int = 1'b0;
        n = 0;
        while (!vec_valid && n < 40) begin step(); n++; end
        chk("vec_valid", vec_valid, 1);
        chk("vec_data", vec_data, v);
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("inta_idle", busy, 0);
        step();
        chk("vec_count", n_vec - vbase, 1);
`ifdef PIC_SEQ_AUTO_EOI_EN
        chk("inta_nev", ev_q.size() - base, 3);
`else
        chk("inta_nev", ev_q.size() - base, 2);
`endif
        check_inta_events(base);
    endtask

    initial begin
        int base, cbase, k, n;
        logic [7:0] r;
        repeat (3) step();
        chk("rst_strobes", {pic_cs_n, pic_rd_n, pic_wr_n, pic_inta_n}, 4'hF);
        chk("rst_bus", {pic_a0, pic_d_oe, pic_d_out}, 10'h000);
        chk("rst_flags", {init_done, busy, rsp_valid, vec_valid, cmd_ready}, 5'h00);
        chk("rst_data", {rsp_rdata, vec_data}, 16'h0000);
        rst_n = 1'b1;
        step();

        // Commands are stalled before init.
        base  = ev_q.size();
        cbase = cs_runs.size();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_a0 = 1'b1; cmd_wdata = 8'hA5;
        k = 0;
        repeat (12) begin step(); if (cmd_ready) k++; end
        cmd_valid = 1'b0;
        chk("preinit_ready", k, 0);
        chk("preinit_events", ev_q.size() - base, 0);
        chk("preinit_cs", cs_runs.size() - cbase, 0);
        chk("preinit_busy", busy, 0);

        run_init(8'h11, 8'h20, 8'h04, 8'h01, 8'hFB);
        run_init(8'h13, 8'h20, 8'h04, 8'h01, 8'hFB);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            run_init({r[7:2], 2'(i)}, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 10; i++)
            run_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

        run_inta(8'h24);
        run_inta(8'($urandom));

        // Command presented in the same cycle the synchronized INT rises.
        base = ev_q.size();
        pic_d_in = 8'h24;
        pic_int  = 1'b1;
        step();
        step();
        chk("prio_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_a0 = 1'b1;
        n = 0;
        while (pic_inta_n && n < 20) begin step(); n++; end
        chk("prio_inta_first", pic_inta_n, 0);
        pic_int = 1'b0;
        n = 0;
        while (!vec_valid && n < 40) begin step(); n++; end
        chk("prio_vec", vec_data, 8'h24);
        pic_d_in = 8'h5A;
        n = 0;
        while (!rsp_valid && n < 60) begin step(); n++; end
        cmd_valid = 1'b0;
        chk("prio_rsp_valid", rsp_valid, 1);
        chk("prio_rsp_rdata", rsp_rdata, 8'h5A);
        step();
        check_inta_events(base);
        if (ev_q.size() > base) begin
            chk("prio_last_kind", ev_q[ev_q.size()-1].k, EV_R);
            chk("prio_last_a0", ev_q[ev_q.size()-1].a0, 1);
        end
        n = 0;
        while (busy && n < 40) begin step(); n++; end

        run_cmd(1'b0, 1'b0, 8'h00, 8'($urandom));

        chk("oe_rules", bad_oe, 0);
        chk("cs_during_inta", bad_cs_inta, 0);
        chk("rsp_in_hold", bad_rsp_slot, 0);

        // Asynchronous reset in the middle of a WR_n pulse.
        cmd_wr = 1'b1; cmd_a0 = 1'b1; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
        n = 0;
        while (pic_wr_n && n < 50) begin step(); n++; end
        cmd_valid = 1'b0;
        chk("midwr_active", pic_wr_n, 0);
        rst_n = 1'b0;
        #1;
        chk("midwr_strobes", {pic_wr_n, pic_cs_n, pic_rd_n, pic_inta_n}, 4'hF);
        chk("midwr_oe", pic_d_oe, 0);
        chk("midwr_flags", {init_done, busy}, 2'b00);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
